mac_tx_feeder: RTL and testbench
================================

Name: mac_tx_feeder

Overview:
Upstream companion to the RMII transmit MAC. It buffers 16-bit payload words from the core through a valid/ready interface in a small FIFO. It launches one MAC frame per word by presenting `tx_data` and a single-cycle `tx_start` pulse. It holds `tx_data` stable, and withholds further starts, for a fixed frame-plus-gap window, because the MAC has no busy/ready output and samples its data input mid-frame.

Parameters:
- DEPTH, 8, FIFO depth in words; must be a power of two and at least 2.
- FRAME_CYCLES, 360, cooldown cycles after each `tx_start`. Must be at least the MAC's full frame plus inter-packet-gap time in clk cycles (345 for the current MAC).
- CNT_W, 16, width of the `frames_sent` counter.

Ports:
- clk  in  1  system clock (50 MHz RMII reference domain).
- rst  in  1  synchronous, active-high reset.
- in_data  in  16  payload word to transmit.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  FIFO can accept; a transfer occurs on cycles where `in_valid && in_ready`.
- enable  in  1  when low, no new frame is launched; a frame in flight completes normally.
- tx_data  out  16  word driven to the MAC data input; held stable for the whole frame.
- tx_start  out  1  one-cycle start pulse to the MAC.
- busy  out  1  high while in START or HOLD.
- fifo_count  out  $clog2(DEPTH)+1  words currently buffered.
- frames_sent  out  CNT_W  frames launched since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: `tx_start`=0, `tx_data`=0, `frames_sent`=0, FIFO empty (`fifo_count`=0), `in_ready`=0 while `rst` is high.
- Reset places the FSM in HOLD with the counter at 0 and `busy`=1. This lets any MAC frame already in flight finish before a new start.
- `in_ready` = `!full`, registered from FIFO state. It never depends on a same-cycle pop; a full FIFO refuses the write even if a pop occurs that cycle.
- FIFO ordering:
  - Strict FIFO.
  - A word pushed at cycle T is visible as non-empty at T+1.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps `fifo_count` unchanged.
- FSM states:
  - IDLE: `busy`=0. If `enable` and FIFO non-empty, pop the head into `tx_data` and go to START. Otherwise stay.
  - START (1 cycle): `tx_start`=1, increment `frames_sent`, clear the counter, go to HOLD.
  - HOLD: `tx_start`=0. The counter increments each cycle; at FRAME_CYCLES-1, go to IDLE.
- Latency: a word accepted at cycle T into an empty FIFO with the FSM in IDLE and `enable`=1 produces `tx_start`=1 at T+2.
- Start-to-start spacing: at least FRAME_CYCLES+2 cycles. `tx_start` is low for at least FRAME_CYCLES+1 cycles between pulses, which satisfies the MAC's rising-edge detect.
- `tx_data` changes only on the IDLE→START transition. It retains the last word while idle.
- `enable`:
  - Sampled only in IDLE.
  - Deasserting it during START or HOLD does not truncate the window.
  - Pushes are still accepted while `enable` is low.
- Reset mid-frame flushes the FIFO; buffered words are discarded.
- `frames_sent` wraps from all-ones to 0 without saturating.

Decomposition:
- Shared package (mac_pkg):
  - MAC frame timing constants: preamble/header, payload, pad, FCS and IPG lengths in dibits.
  - The derived MAC_FRAME_CYCLES (345), used as the FRAME_CYCLES default floor.
  - FSM state encodings IDLE/START/HOLD.
- One sub-module, `sync_fifo`: width 16, depth DEPTH, outputs full/empty/count, same clk/rst. The FSM and counters live in the top level.

Test Plan:
1. Reset, then push 16'hBEEF at cycle T with the FSM idle → `tx_start` high only at T+2, `tx_data`=16'hBEEF from T+2 until the next launch, `frames_sent`=1.
2. Push 16'h0001, 16'h0002, 16'h0003 back-to-back → three `tx_start` pulses exactly 362 cycles apart (FRAME_CYCLES=360). `tx_data` sequence is 0001, 0002, 0003 and is stable through each window.
3. Hold `enable`=0 and push 9 words with DEPTH=8 → `in_ready` drops after the 8th, the 9th is held off, `fifo_count`=8, no `tx_start`. Raise `enable` → first start 1 cycle later, and `in_ready` returns high.
4. Assert `rst` for 1 cycle at HOLD counter 100 with 3 words buffered → `fifo_count`=0, `tx_start` stays low for 360 cycles. A word pushed immediately after reset launches no earlier than the end of that window.
5. Use CNT_W=4 and send 17 frames → `frames_sent` reads 1 after the 17th, confirming wrap.
6. Instantiate with the MAC, send 16'h1234, and capture `txd` → the payload dibits encode 16'h1234 and exactly one frame appears per word.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared RMII MAC timing constants and feeder FSM encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mac_pkg;

    // MAC frame layout in dibits; one dibit leaves the MAC per 50 MHz clk.
    localparam int MAC_PREAMBLE_HDR_DIBITS = 88;  // 7B preamble + SFD + 14B header
    localparam int MAC_PAYLOAD_DIBITS      = 8;   // one 16-bit word
    localparam int MAC_PAD_DIBITS          = 176; // pad up to the 46B minimum payload
    localparam int MAC_FCS_DIBITS          = 16;  // 32-bit CRC
    localparam int MAC_IPG_DIBITS          = 48;  // 96-bit inter-packet gap
    localparam int MAC_PIPE_CYCLES         = 9;   // start edge detect + CRC flush

    // Full busy time of the MAC for one frame, gap included.
    localparam int MAC_FRAME_CYCLES = MAC_PREAMBLE_HDR_DIBITS + MAC_PAYLOAD_DIBITS +
                                      MAC_PAD_DIBITS + MAC_FCS_DIBITS +
                                      MAC_IPG_DIBITS + MAC_PIPE_CYCLES;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_HOLD  = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count and full/empty flags.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flags come straight from the registered count, never from this cycle's pop.
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; reset flushes all buffered words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_tx_feeder.sv
// Buffers payload words and launches one RMII MAC frame per word.
// Latency: word accepted at T into an idle, empty feeder -> tx_start at T+2.
// Backpressure: in_ready drops when the FIFO is full; starts are spaced FRAME_CYCLES+2 apart.
module mac_tx_feeder
    import mac_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int FRAME_CYCLES = MAC_FRAME_CYCLES + 15,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   enable,
    output logic [15:0]            tx_data,
    output logic                   tx_start,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [CNT_W-1:0]       frames_sent
);
    localparam int HCW = $clog2(FRAME_CYCLES + 1);

    feeder_state_t  state;
    logic [HCW-1:0] hold_cnt;
    logic [15:0]    fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;

    // Ready reflects registered fullness only; held low through reset.
    assign in_ready  = !rst && !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = (state == ST_IDLE) && enable && !fifo_empty;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Launch FSM: reset lands in HOLD so a frame already on the wire can finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            busy        <= 1'b1;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            frames_sent <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && !fifo_empty) begin
                        tx_data     <= fifo_head;
                        tx_start    <= 1'b1;
                        frames_sent <= frames_sent + 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    hold_cnt <= '0;
                    state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (hold_cnt == HCW'(FRAME_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    hold_cnt <= '0;
                    busy     <= 1'b1;
                    state    <= ST_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_feeder.sv
// Self-checking bench for mac_tx_feeder with a window-timing reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mac_tx_feeder;
    localparam int DEPTH = 8;
    localparam int FRAME = 360;
    localparam int CW    = 4;
    localparam int GAP   = FRAME + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        enable = 1'b0;
    logic        in_ready;
    logic [15:0] tx_data;
    logic        tx_start;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [CW-1:0] frames_sent;

    mac_tx_feeder #(.DEPTH(DEPTH), .FRAME_CYCLES(FRAME), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .enable(enable), .tx_data(tx_data),
        .tx_start(tx_start), .busy(busy), .fifo_count(fifo_count),
        .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words queue, earliest cycle the feeder may be idle again.
    logic [15:0]   mq[$];
    logic [15:0]   m_data = '0;
    logic [CW-1:0] m_frames = '0;
    int            idle_from = 32'h7fff_ffff;
    bit            exp_start = 1'b0;
    logic [3:0]    exp_cnt;
    logic          exp_rdy;
    logic          exp_busy;
    // Observed launches, recorded from the DUT pins.
    int            obs_starts[$];
    logic [15:0]   obs_data[$];

    always @(negedge clk) begin
        if (exp_start) begin
            if (mq.size() > 0) m_data = mq.pop_front();
            m_frames  = m_frames + 1'b1;
            idle_from = cyc + FRAME + 1;
        end
        if (tx_start === 1'b1) begin
            obs_starts.push_back(cyc);
            obs_data.push_back(tx_data);
        end
        exp_cnt  = 4'(mq.size());
        exp_rdy  = !rst && (mq.size() < DEPTH);
        exp_busy = (cyc < idle_from);
        n_cmp++;
        if (tx_start !== exp_start) begin
            if (n_bad < 30) $display("FAIL mon_tx_start cyc=%0d got=%b want=%b", cyc, tx_start, exp_start);
            n_bad++;
        end
        n_cmp++;
        if (tx_data !== m_data) begin
            if (n_bad < 30) $display("FAIL mon_tx_data cyc=%0d got=%h want=%h", cyc, tx_data, m_data);
            n_bad++;
        end
        n_cmp++;
        if (frames_sent !== m_frames) begin
            if (n_bad < 30) $display("FAIL mon_frames cyc=%0d got=%0d want=%0d", cyc, frames_sent, m_frames);
            n_bad++;
        end
        n_cmp++;
        if (fifo_count !== exp_cnt) begin
            if (n_bad < 30) $display("FAIL mon_count cyc=%0d got=%0d want=%0d", cyc, fifo_count, exp_cnt);
            n_bad++;
        end
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            if (n_bad < 30) $display("FAIL mon_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, exp_rdy);
            n_bad++;
        end
        n_cmp++;
        if (busy !== exp_busy) begin
            if (n_bad < 30) $display("FAIL mon_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            n_bad++;
        end
        if (rst) begin
            mq.delete();
            m_data    = '0;
            m_frames  = '0;
            idle_from = cyc + FRAME + 1;
            exp_start = 1'b0;
        end else begin
            exp_start = (cyc >= idle_from) && enable && (mq.size() > 0);
            if (in_valid && in_ready) mq.push_back(in_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] w, output int t);
        in_valid = 1'b1;
        in_data  = w;
        t = -1;
        for (int k = 0; k < 3000; k++) begin
            if (in_ready) begin
                t = cyc;
                step();
                break;
            end
            step();
        end
        in_valid = 1'b0;
        if (t < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout word=%h got=no_ready want=ready", w);
        end
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (busy === 1'b0 && fifo_count === 4'd0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle_timeout got=busy=%b,count=%0d want=idle", busy, fifo_count);
        end
    endtask

    task automatic wait_starts(input int n, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (obs_starts.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_starts_timeout got=%0d want=%0d", obs_starts.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 16'h0 || frames_sent !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%b/%h/%0d want=0/0000/0", tx_start, tx_data, frames_sent);
        end
        n_cmp++;
        if (fifo_count !== 4'd0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_fifo got=cnt%0d rdy%b busy%b want=cnt0 rdy0 busy1", fifo_count, in_ready, busy);
        end
        rst = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_single();
        int t;
        int b;
        wait_idle(800);
        b = obs_starts.size();
        push(16'hBEEF, t);
        n_cmp++;
        if (tx_start !== 1'b0) begin
            n_bad++; $display("FAIL single_t1 got=%b want=0", tx_start);
        end
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== 16'hBEEF) begin
            n_bad++; $display("FAIL single_t2 got=%b/%h want=1/beef", tx_start, tx_data);
        end
        step();
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 16'hBEEF || frames_sent !== 4'd1) begin
            n_bad++; $display("FAIL single_t3 got=%b/%h/%0d want=0/beef/1", tx_start, tx_data, frames_sent);
        end
        n_cmp++;
        if (obs_starts.size() != b + 1 || obs_starts[b] != t + 2) begin
            n_bad++; $display("FAIL single_latency got=%0d want=%0d", obs_starts.size() > b ? obs_starts[b] - t : -1, 2);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t;
        int b;
        wait_idle(800);
        b = obs_starts.size();
        push(16'h0001, t0);
        push(16'h0002, t);
        push(16'h0003, t);
        wait_starts(b + 3, 3 * GAP + 50);
        if (obs_starts.size() >= b + 3) begin
            n_cmp++;
            if (obs_starts[b] != t0 + 2) begin
                n_bad++; $display("FAIL b2b_first got=%0d want=%0d", obs_starts[b], t0 + 2);
            end
            for (int i = 1; i < 3; i++) begin
                n_cmp++;
                if (obs_starts[b + i] - obs_starts[b + i - 1] != GAP) begin
                    n_bad++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, obs_starts[b + i] - obs_starts[b + i - 1], GAP);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (obs_data[b + i] !== 16'(i + 1)) begin
                    n_bad++; $display("FAIL b2b_data%0d got=%h want=%h", i, obs_data[b + i], 16'(i + 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] words[9];
        int t;
        int b;
        wait_idle(800);
        enable = 1'b0;
        b = obs_starts.size();
        foreach (words[i]) words[i] = 16'($urandom);
        for (int i = 0; i < 8; i++) push(words[i], t);
        in_valid = 1'b1;
        in_data  = words[8];
        repeat (3) step();
        n_cmp++;
        if (in_ready !== 1'b0 || fifo_count !== 4'd8 || obs_starts.size() != b) begin
            n_bad++; $display("FAIL bp_full got=rdy%b cnt%0d starts%0d want=rdy0 cnt8 starts%0d", in_ready, fifo_count, obs_starts.size(), b);
        end
        enable = 1'b1;
        step();
        n_cmp++;
        if (tx_start !== 1'b1 || in_ready !== 1'b1 || tx_data !== words[0]) begin
            n_bad++; $display("FAIL bp_release got=st%b rdy%b %h want=st1 rdy1 %h", tx_start, in_ready, tx_data, words[0]);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd8) begin
            n_bad++; $display("FAIL bp_ninth got=%0d want=8", fifo_count);
        end
        wait_starts(b + 9, 9 * GAP + 100);
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (obs_starts.size() <= b + i || obs_data[b + i] !== words[i]) begin
                n_bad++; $display("FAIL bp_order%0d got=%h want=%h", i, obs_starts.size() > b + i ? obs_data[b + i] : 16'hxxxx, words[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t;
        int b;
        int s;
        int r;
        wait_idle(800);
        b = obs_starts.size();
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i), t);
        wait_starts(b + 1, 50);
        s = (obs_starts.size() > b) ? obs_starts[b] : cyc;
        for (int k = 0; k < 200 && cyc < s + 101; k++) step();
        n_cmp++;
        if (fifo_count !== 4'd3) begin
            n_bad++; $display("FAIL mid_buffered got=%0d want=3", fifo_count);
        end
        rst = 1'b1;
        r = cyc;
        step();
        rst = 1'b0;
        n_cmp++;
        if (fifo_count !== 4'd0 || busy !== 1'b1 || frames_sent !== '0) begin
            n_bad++; $display("FAIL mid_flush got=cnt%0d busy%b fr%0d want=cnt0 busy1 fr0", fifo_count, busy, frames_sent);
        end
        push(16'h5A5A, t);
        wait_starts(b + 2, 500);
        n_cmp++;
        if (obs_starts.size() != b + 2 || obs_starts[b + 1] != r + GAP || obs_data[b + 1] !== 16'h5A5A) begin
            n_bad++; $display("FAIL mid_relaunch got=%0d want=%0d", obs_starts.size() > b + 1 ? obs_starts[b + 1] - r : -1, GAP);
        end
    endtask

    task automatic test_wrap();
        int t;
        int b;
        rst = 1'b1;
        step();
        rst = 1'b0;
        b = obs_starts.size();
        for (int i = 0; i < 17; i++) push(16'($urandom), t);
        wait_starts(b + 17, 17 * GAP + 200);
        step();
        n_cmp++;
        if (frames_sent !== 4'd1 || obs_starts.size() != b + 17) begin
            n_bad++; $display("FAIL wrap got=%0d/%0d want=1/17", frames_sent, obs_starts.size() - b);
        end
    endtask

    task automatic test_random();
        int t;
        int b;
        wait_idle(800);
        b = obs_starts.size();
        for (int i = 0; i < 14; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            push(16'($urandom), t);
            repeat ($urandom_range(0, 300)) step();
        end
        enable = 1'b1;
        wait_idle(14 * GAP + 100);
        n_cmp++;
        if (obs_starts.size() != b + 14) begin
            n_bad++; $display("FAIL rand_count got=%0d want=14", obs_starts.size() - b);
        end
        for (int i = b + 1; i < obs_starts.size(); i++) begin
            n_cmp++;
            if (obs_starts[i] - obs_starts[i - 1] < GAP) begin
                n_bad++; $display("FAIL rand_spacing%0d got=%0d want>=%0d", i - b, obs_starts[i] - obs_starts[i - 1], GAP);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=cycle%0d want=completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
